bsg_mem_1rw_sync_mask_write_bit_tiled: RTL and testbench



---
 rtl/bsg_mem_1rw_sync_mask_write_bit_tiled.sv | 153 +++++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_tiled.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_tiled.sv
// Single-port synchronous RAM with per-bit write mask, built from a grid of
// tile_els_p x tile_width_p tiles; owns row select, read-valid and output staging.
module bsg_mem_1rw_sync_mask_write_bit_tiled #(
    parameter int width_p           = -1,
    parameter int els_p             = -1,
    parameter int tile_width_p      = 64,
    parameter int tile_els_p        = 512,
    parameter int latch_last_read_p = 1,
    parameter int output_reg_p      = 0,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o,
    output logic                     data_v_o
);

    localparam int tile_lg_els_lp     = (tile_els_p > 1) ? $clog2(tile_els_p) : 0;
    localparam int tile_addr_width_lp = (tile_els_p > 1) ? $clog2(tile_els_p) : 1;
    localparam int rows_lp            = (els_p + tile_els_p - 1) / tile_els_p;
    localparam int cols_lp            = (width_p + tile_width_p - 1) / tile_width_p;
    localparam int row_width_lp       = (rows_lp > 1) ? $clog2(rows_lp) : 1;
    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

    if (width_p < 1 || els_p < 2) begin : g_bad_geometry
        $error("bsg_mem_1rw_sync_mask_write_bit_tiled: need width_p >= 1 and els_p >= 2");
    end

    if (tile_els_p < 1 || (tile_els_p & (tile_els_p - 1)) != 0) begin : g_bad_tile_els
        $error("bsg_mem_1rw_sync_mask_write_bit_tiled: tile_els_p must be a power of 2");
    end

    logic                          in_range;
    logic [row_width_lp-1:0]       row_sel;
    logic [tile_addr_width_lp-1:0] tile_addr;
    logic [rows_lp-1:0]            tile_ce;
    logic [rows_lp-1:0][width_p-1:0] tile_rdata;

    logic                    rd_v_q;
    logic [row_width_lp-1:0] row_q;
    logic                    oor_q;
    logic [width_p-1:0]      row_data;
    logic [width_p-1:0]      rd_data;

    always_comb begin
        in_range  = {1'b0, addr_i} < els_lp;
        row_sel   = row_width_lp'(addr_i >> tile_lg_els_lp);
        tile_addr = tile_addr_width_lp'(addr_i & addr_width_lp'(tile_els_p - 1));
        tile_ce   = '0;
        for (int r = 0; r < rows_lp; r++) begin
            if (v_i && !reset_i && in_range && (row_sel == row_width_lp'(r))) begin
                tile_ce[r] = 1'b1;
            end
        end
    end

    // Each tile stores only the live bits of its column; the padded tail of the
    // last column would always be written as zero and never reach data_o.
    for (genvar r = 0; r < rows_lp; r++) begin : g_row
        for (genvar c = 0; c < cols_lp; c++) begin : g_col
            localparam int col_lo_lp = c * tile_width_p;
            localparam int col_w_lp  = (width_p - col_lo_lp < tile_width_p)
                                       ? (width_p - col_lo_lp) : tile_width_p;

            logic [col_w_lp-1:0] mem [tile_els_p];
            logic [col_w_lp-1:0] rdata_q;
            logic [col_w_lp-1:0] wdata;
            logic [col_w_lp-1:0] wmask;

            assign wdata = data_i[col_lo_lp +: col_w_lp];
            assign wmask = w_mask_i[col_lo_lp +: col_w_lp];

            always_ff @(posedge clk_i) begin
                if (tile_ce[r]) begin
                    if (w_i) begin
                        mem[tile_addr] <= (mem[tile_addr] & ~wmask) | (wdata & wmask);
                    end else begin
                        rdata_q <= mem[tile_addr];
                    end
                end
            end

            assign tile_rdata[r][col_lo_lp +: col_w_lp] = rdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v_q <= 1'b0;
            row_q  <= '0;
            oor_q  <= 1'b0;
        end else begin
            rd_v_q <= v_i & ~w_i;
            if (v_i && !w_i) begin
                row_q <= row_sel;
                oor_q <= ~in_range;
            end
        end
    end

    always_comb begin
        row_data = '0;
        for (int r = 0; r < rows_lp; r++) begin
            if (row_q == row_width_lp'(r)) begin
                row_data = tile_rdata[r];
            end
        end
        // Out-of-range reads enabled no tile, so force a zero result.
        rd_data = oor_q ? '0 : row_data;
    end

    if (output_reg_p != 0) begin : g_out_reg
        logic               out_v_q;
        logic [width_p-1:0] out_data_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                out_v_q    <= 1'b0;
                out_data_q <= '0;
            end else begin
                out_v_q <= rd_v_q;
                if (rd_v_q || (latch_last_read_p == 0)) begin
                    out_data_q <= rd_data;
                end
            end
        end

        assign data_v_o = out_v_q;
        assign data_o   = out_data_q;
    end else if (latch_last_read_p != 0) begin : g_latch
        logic [width_p-1:0] last_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                last_q <= '0;
            end else if (rd_v_q) begin
                last_q <= rd_data;
            end
        end

        assign data_v_o = rd_v_q;
        assign data_o   = rd_v_q ? rd_data : last_q;
    end else begin : g_direct
        assign data_v_o = rd_v_q;
        assign data_o   = rd_data;
    end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_tiled.sv
// Bench: two configurations (80x1024 latency 1, 80x600 latency 2) against
// array reference models with random and directed accesses.
module tb_bsg_mem_1rw_sync_mask_write_bit_tiled;

    localparam int W = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic         a_v, a_w, a_dv;
    logic [9:0]   a_addr;
    logic [W-1:0] a_data, a_mask, a_q;

    logic         b_v, b_w, b_dv;
    logic [9:0]   b_addr;
    logic [W-1:0] b_data, b_mask, b_q;

    bsg_mem_1rw_sync_mask_write_bit_tiled #(
        .width_p(W),
        .els_p  (1024)
    ) dut_a (
        .clk_i   (clk),
        .reset_i (reset),
        .v_i     (a_v),
        .w_i     (a_w),
        .addr_i  (a_addr),
        .data_i  (a_data),
        .w_mask_i(a_mask),
        .data_o  (a_q),
        .data_v_o(a_dv)
    );

    bsg_mem_1rw_sync_mask_write_bit_tiled #(
        .width_p     (W),
        .els_p       (600),
        .output_reg_p(1)
    ) dut_b (
        .clk_i   (clk),
        .reset_i (reset),
        .v_i     (b_v),
        .w_i     (b_w),
        .addr_i  (b_addr),
        .data_i  (b_data),
        .w_mask_i(b_mask),
        .data_o  (b_q),
        .data_v_o(b_dv)
    );

    logic [W-1:0] mem_a [1024];
    logic [W-1:0] mem_b [600];
    logic [W-1:0] last_a, last_b;
    int n_checks, n_fail;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
    } exp_t;
    exp_t q_b[$];

    function automatic logic [W-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Drive one access at the falling edge; return at the next falling edge.
    task automatic step_a(input logic pv, input logic pw, input logic [9:0] pa,
                          input logic [W-1:0] pd, input logic [W-1:0] pm);
        a_v = pv; a_w = pw; a_addr = pa; a_data = pd; a_mask = pm;
        @(negedge clk);
        if (pv && pw && !reset) mem_a[pa] = (mem_a[pa] & ~pm) | (pd & pm);
    endtask

    task automatic step_b(input logic pv, input logic pw, input logic [9:0] pa,
                          input logic [W-1:0] pd, input logic [W-1:0] pm);
        b_v = pv; b_w = pw; b_addr = pa; b_data = pd; b_mask = pm;
        @(negedge clk);
        if (pv && pw && !reset && pa < 10'd600) mem_b[pa] = (mem_b[pa] & ~pm) | (pd & pm);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_dv !== 1'b0) begin n_fail++; $display("FAIL reset_a_v: got %b want 0", a_dv); end
        n_checks++;
        if (a_q !== '0) begin n_fail++; $display("FAIL reset_a_data: got %h want 0", a_q); end
        n_checks++;
        if (b_dv !== 1'b0) begin n_fail++; $display("FAIL reset_b_v: got %b want 0", b_dv); end
        n_checks++;
        if (b_q !== '0) begin n_fail++; $display("FAIL reset_b_data: got %h want 0", b_q); end
        reset = 1'b0;
        last_a = '0;
        last_b = '0;
        @(negedge clk);
    endtask

    task automatic test_preload();
        for (int i = 0; i < 1024; i++) begin
            step_a(1'b1, 1'b1, 10'(i), rand_word(), '1);
            n_checks++;
            if (a_dv !== 1'b0) begin n_fail++; $display("FAIL preload_a_v: got %b want 0", a_dv); end
        end
        step_a(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 600; i++) begin
            step_b(1'b1, 1'b1, 10'(i), rand_word(), '1);
        end
        step_b(1'b0, 1'b0, '0, '0, '0);
        step_b(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (b_dv !== 1'b0) begin n_fail++; $display("FAIL preload_b_v: got %b want 0", b_dv); end
    endtask

    task automatic test_basic();
        logic [W-1:0] pat;
        pat = {10{8'hA5}};
        step_a(1'b1, 1'b1, 10'h005, pat, '1);
        step_a(1'b1, 1'b0, 10'h005, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1) begin n_fail++; $display("FAIL basic_v: got %b want 1", a_dv); end
        n_checks++;
        if (a_q !== pat) begin n_fail++; $display("FAIL basic_data: got %h want %h", a_q, pat); end
        last_a = pat;
        step_a(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_row_cross();
        logic [W-1:0] x1, x2;
        x1 = rand_word();
        x2 = ~x1;
        step_a(1'b1, 1'b1, 10'h1FF, x1, '1);
        step_a(1'b1, 1'b1, 10'h200, x2, '1);
        step_a(1'b1, 1'b0, 10'h1FF, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1 || a_q !== x1) begin
            n_fail++; $display("FAIL row_cross_1ff: got v=%b %h want v=1 %h", a_dv, a_q, x1);
        end
        step_a(1'b1, 1'b0, 10'h200, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1 || a_q !== x2) begin
            n_fail++; $display("FAIL row_cross_200: got v=%b %h want v=1 %h", a_dv, a_q, x2);
        end
        last_a = x2;
        step_a(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_mask_boundary();
        logic [W-1:0] m, want;
        m = '0;
        m[70:60] = '1;
        want = ((80'd1 << 11) - 80'd1) << 60;
        step_a(1'b1, 1'b1, 10'd3, '0, '1);
        step_a(1'b1, 1'b1, 10'd3, '1, m);
        step_a(1'b1, 1'b0, 10'd3, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1 || a_q !== want) begin
            n_fail++; $display("FAIL mask_boundary: got v=%b %h want v=1 %h", a_dv, a_q, want);
        end
        last_a = want;
        step_a(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_latch();
        logic [W-1:0] want;
        want = mem_a[3];
        step_a(1'b1, 1'b0, 10'd3, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1 || a_q !== want) begin
            n_fail++; $display("FAIL latch_read: got v=%b %h want v=1 %h", a_dv, a_q, want);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) step_a(1'b1, 1'b1, 10'd100, rand_word(), '1);
            else        step_a(1'b0, 1'b0, '0, '0, '0);
            n_checks++;
            if (a_dv !== 1'b0 || a_q !== want) begin
                n_fail++; $display("FAIL latch_hold: cycle %0d got v=%b %h want v=0 %h", i, a_dv, a_q, want);
            end
        end
        last_a = want;
    endtask

    task automatic test_random_a();
        logic         v, w;
        logic [9:0]   addr;
        logic [W-1:0] d, m, want;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            w    = $urandom_range(0, 1) == 1;
            addr = 10'($urandom_range(0, 1023));
            d    = rand_word();
            m    = ($urandom_range(0, 3) == 0) ? '1 : rand_word();
            want = mem_a[addr];
            step_a(v, w, addr, d, m);
            n_checks++;
            if (v && !w) begin
                if (a_dv !== 1'b1 || a_q !== want) begin
                    n_fail++; $display("FAIL rand_a_read: i=%0d addr=%0d got v=%b %h want v=1 %h", i, addr, a_dv, a_q, want);
                end
                last_a = want;
            end else if (a_dv !== 1'b0 || a_q !== last_a) begin
                n_fail++; $display("FAIL rand_a_idle: i=%0d got v=%b %h want v=0 %h", i, a_dv, a_q, last_a);
            end
        end
        step_a(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_oor_b();
        logic [W-1:0] want;
        step_b(1'b1, 1'b0, 10'd650, '0, '0);
        n_checks++;
        if (b_dv !== 1'b0 || b_q !== last_b) begin
            n_fail++; $display("FAIL oor_latency1: got v=%b %h want v=0 %h", b_dv, b_q, last_b);
        end
        step_b(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (b_dv !== 1'b1 || b_q !== '0) begin
            n_fail++; $display("FAIL oor_read: got v=%b %h want v=1 0", b_dv, b_q);
        end
        last_b = '0;
        step_b(1'b1, 1'b1, 10'd650, rand_word(), '1);
        for (int k = 0; k < 2; k++) begin
            want = mem_b[(k == 0) ? 138 : 599];
            step_b(1'b1, 1'b0, (k == 0) ? 10'd138 : 10'd599, '0, '0);
            step_b(1'b0, 1'b0, '0, '0, '0);
            n_checks++;
            if (b_dv !== 1'b1 || b_q !== want) begin
                n_fail++; $display("FAIL oor_write_dropped: k=%0d got v=%b %h want v=1 %h", k, b_dv, b_q, want);
            end
            last_b = want;
        end
        step_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_random_b();
        logic         v, w;
        logic [9:0]   addr;
        logic [W-1:0] d, m;
        exp_t         e, got;
        step_b(1'b0, 1'b0, '0, '0, '0);
        step_b(1'b0, 1'b0, '0, '0, '0);
        q_b.delete();
        e.v = 1'b0; e.d = '0;
        q_b.push_back(e);
        for (int i = 0; i < 301; i++) begin
            if (i == 300) begin
                v = 1'b0; w = 1'b0; addr = '0;
            end else begin
                v    = ($urandom_range(0, 3) != 0);
                w    = $urandom_range(0, 1) == 1;
                addr = 10'($urandom_range(0, 1023));
            end
            d = rand_word();
            m = rand_word();
            e.v = v && !w;
            e.d = (addr < 10'd600) ? mem_b[addr] : '0;
            step_b(v, w, addr, d, m);
            q_b.push_back(e);
            got = q_b.pop_front();
            n_checks++;
            if (got.v) begin
                if (b_dv !== 1'b1 || b_q !== got.d) begin
                    n_fail++; $display("FAIL rand_b_read: i=%0d got v=%b %h want v=1 %h", i, b_dv, b_q, got.d);
                end
                last_b = got.d;
            end else if (b_dv !== 1'b0 || b_q !== last_b) begin
                n_fail++; $display("FAIL rand_b_idle: i=%0d got v=%b %h want v=0 %h", i, b_dv, b_q, last_b);
            end
        end
        step_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset_mid_read();
        logic [W-1:0] want;
        step_a(1'b1, 1'b0, 10'h1FF, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1) begin n_fail++; $display("FAIL rst_a_pre_v: got %b want 1", a_dv); end
        reset = 1'b1;
        step_a(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (a_dv !== 1'b0 || a_q !== '0) begin
            n_fail++; $display("FAIL rst_a_clear: got v=%b %h want v=0 0", a_dv, a_q);
        end
        want = mem_a[5];
        step_a(1'b1, 1'b1, 10'd5, ~want, '1);
        step_a(1'b1, 1'b0, 10'd7, '0, '0);
        step_a(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (a_dv !== 1'b0 || a_q !== '0) begin
            n_fail++; $display("FAIL rst_a_read_ignored: got v=%b %h want v=0 0", a_dv, a_q);
        end
        reset = 1'b0;
        last_a = '0;
        last_b = '0;
        step_a(1'b1, 1'b0, 10'd5, '0, '0);
        n_checks++;
        if (a_dv !== 1'b1 || a_q !== want) begin
            n_fail++; $display("FAIL rst_a_preserved: got v=%b %h want v=1 %h", a_dv, a_q, want);
        end
        step_a(1'b0, 1'b0, '0, '0, '0);

        want = mem_b[138];
        step_b(1'b1, 1'b0, 10'd138, '0, '0);
        reset = 1'b1;
        step_b(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (b_dv !== 1'b0 || b_q !== '0) begin
            n_fail++; $display("FAIL rst_b_discard: got v=%b %h want v=0 0", b_dv, b_q);
        end
        step_b(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (b_dv !== 1'b0 || b_q !== '0) begin
            n_fail++; $display("FAIL rst_b_hold: got v=%b %h want v=0 0", b_dv, b_q);
        end
        reset = 1'b0;
        step_b(1'b1, 1'b0, 10'd138, '0, '0);
        step_b(1'b0, 1'b0, '0, '0, '0);
        n_checks++;
        if (b_dv !== 1'b1 || b_q !== want) begin
            n_fail++; $display("FAIL rst_b_preserved: got v=%b %h want v=1 %h", b_dv, b_q, want);
        end
        last_b = want;
        step_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        a_v = 1'b0; a_w = 1'b0; a_addr = '0; a_data = '0; a_mask = '0;
        b_v = 1'b0; b_w = 1'b0; b_addr = '0; b_data = '0; b_mask = '0;
        @(negedge clk);
        test_reset();
        test_preload();
        test_basic();
        test_row_cross();
        test_mask_boundary();
        test_latch();
        test_random_a();
        test_oor_b();
        test_random_b();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
